// File: rtl/sisc_exec_ctrl_if.sv
// Bus between the SISC execute/control core and the surrounding datapath:
// IR fields, register data and status in; ALU results, branch target and datapath controls out.
interface sisc_exec_ctrl_if;
  logic [31:0] ir;
  logic [31:0] rsa;
  logic [31:0] rsb;
  logic [15:0] pc_inc;
  logic [3:0]  statcode;
  logic [31:0] alu_result;
  logic [3:0]  stat;
  logic        stat_en;
  logic [15:0] br_addr;
  logic        pc_rst;
  logic        pc_write;
  logic        pc_sel;
  logic        br_sel;
  logic        rf_we;
  logic        wb_sel;
  logic        rd_sel;
  logic        mm_sel;
  logic        dm_we;
  logic        rs_en;
  logic        rsort_sel;
  logic        data_sel;
  logic        halted;

  modport master (
    output ir, rsa, rsb, pc_inc, statcode,
    input  alu_result, stat, stat_en, br_addr, pc_rst, pc_write, pc_sel, br_sel,
           rf_we, wb_sel, rd_sel, mm_sel, dm_we, rs_en, rsort_sel, data_sel, halted
  );

  modport slave (
    input  ir, rsa, rsb, pc_inc, statcode,
    output alu_result, stat, stat_en, br_addr, pc_rst, pc_write, pc_sel, br_sel,
           rf_we, wb_sel, rd_sel, mm_sel, dm_we, rs_en, rsort_sel, data_sel, halted
  );
endinterface

// File: rtl/sisc_exec_ctrl.sv
// SISC multicycle core: instruction-sequencing FSM, 32-bit ALU with {C,V,N,Z} status
// and branch-target adder. Controls, ALU and branch address are combinational.
module sisc_exec_ctrl (
  input  logic             clk,
  input  logic             rst_f,
  sisc_exec_ctrl_if.slave  bus
);
  typedef enum logic [2:0] {
    S_START0    = 3'd0,
    S_START1    = 3'd1,
    S_FETCH     = 3'd2,
    S_DECODE    = 3'd3,
    S_EXECUTE   = 3'd4,
    S_MEM       = 3'd5,
    S_WRITEBACK = 3'd6,
    S_HALT      = 3'd7
  } state_t;

  localparam logic [3:0] OP_ALU = 4'h1;
  localparam logic [3:0] OP_LOD = 4'h2;
  localparam logic [3:0] OP_STR = 4'h3;
  localparam logic [3:0] OP_BRA = 4'h4;
  localparam logic [3:0] OP_BRR = 4'h5;
  localparam logic [3:0] OP_BNE = 4'h6;
  localparam logic [3:0] OP_BNR = 4'h7;
  localparam logic [3:0] OP_SWP = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  w_op;
  logic [3:0]  w_mm;
  logic [15:0] w_imm;
  logic [31:0] w_sext;
  logic        w_unused_fields;
  logic [31:0] w_b;
  logic [31:0] w_b_eff;
  logic [2:0]  w_fn;
  logic        w_sub;
  logic        w_arith;
  logic        w_v;
  logic [32:0] w_sum;
  logic [31:0] w_res;
  logic        w_hit;
  logic        w_taken;
  logic        w_abs;
  logic        w_mem_op;
  logic [15:0] w_br;

  assign w_op            = bus.ir[31:28];
  assign w_mm            = bus.ir[27:24];
  assign w_imm           = bus.ir[15:0];
  assign w_sext          = {{16{w_imm[15]}}, w_imm};
  assign w_unused_fields = ^bus.ir[23:16];
  assign w_mem_op        = (w_op == OP_LOD) || (w_op == OP_STR);
  assign w_abs           = (w_op == OP_BRA) || (w_op == OP_BNE);

  // State register
  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      r_state <= S_START0;
    end else begin
      r_state <= w_next;
    end
  end

  // Sequencing: every non-halt instruction walks all five phases
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_START0:    w_next = S_START1;
      S_START1:    w_next = S_FETCH;
      S_FETCH:     w_next = S_DECODE;
      S_DECODE:    w_next = (w_op == OP_HLT) ? S_HALT : S_EXECUTE;
      S_EXECUTE:   w_next = S_MEM;
      S_MEM:       w_next = S_WRITEBACK;
      S_WRITEBACK: w_next = S_FETCH;
      S_HALT:      w_next = S_HALT;
      default:     w_next = S_START0;
    endcase
  end

  // ALU; non-ALU opcodes reuse the adder for rsa + sext(imm) address generation
  always_comb begin
    if ((w_op == OP_ALU) && !w_mm[3]) begin
      w_b = bus.rsb;
    end else begin
      w_b = w_sext;
    end
    if (w_op == OP_ALU) begin
      w_fn = w_mm[2:0];
    end else begin
      w_fn = 3'b000;
    end
    w_sub   = (w_fn == 3'b001);
    w_arith = (w_fn == 3'b000) || w_sub;
    w_b_eff = w_sub ? ~w_b : w_b;
    w_sum   = {1'b0, bus.rsa} + {1'b0, w_b_eff} + {32'd0, w_sub};
    w_v     = w_arith && (bus.rsa[31] == w_b_eff[31]) && (w_sum[31] != bus.rsa[31]);
    case (w_fn)
      3'b010:  w_res = bus.rsa & w_b;
      3'b011:  w_res = bus.rsa | w_b;
      3'b100:  w_res = bus.rsa ^ w_b;
      3'b101:  w_res = ~bus.rsa;
      3'b110:  w_res = bus.rsa << w_b[4:0];
      3'b111:  w_res = bus.rsa >> w_b[4:0];
      default: w_res = w_sum[31:0];
    endcase
  end

  // Branch condition and target
  always_comb begin
    w_hit = ((bus.statcode & w_mm) != 4'd0);
    if ((w_op == OP_BRA) || (w_op == OP_BRR)) begin
      w_taken = w_hit;
    end else if ((w_op == OP_BNE) || (w_op == OP_BNR)) begin
      w_taken = !w_hit;
    end else begin
      w_taken = 1'b0;
    end
    w_br = w_abs ? w_imm : (bus.pc_inc + w_imm);
  end

  // Datapath outputs, forced to zero while the core is in its reset state
  always_comb begin
    if (r_state == S_START0) begin
      bus.alu_result = 32'd0;
      bus.stat       = 4'd0;
      bus.br_addr    = 16'd0;
    end else begin
      bus.alu_result = w_res;
      bus.stat       = {w_arith & w_sum[32], w_v, w_res[31], (w_res == 32'd0)};
      bus.br_addr    = w_br;
    end
  end

  // Control decode from state and instruction
  always_comb begin
    bus.pc_rst    = 1'b0;
    bus.pc_write  = 1'b0;
    bus.pc_sel    = 1'b0;
    bus.br_sel    = 1'b0;
    bus.rf_we     = 1'b0;
    bus.wb_sel    = 1'b0;
    bus.rd_sel    = 1'b0;
    bus.mm_sel    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.rs_en     = 1'b0;
    bus.rsort_sel = 1'b0;
    bus.data_sel  = 1'b0;
    bus.stat_en   = 1'b0;
    bus.halted    = 1'b0;
    case (r_state)
      S_START0: bus.pc_rst = 1'b1;
      S_FETCH:  bus.pc_write = 1'b1;
      S_DECODE: begin
        bus.br_sel = w_abs;
        if (w_taken) begin
          bus.pc_write = 1'b1;
          bus.pc_sel   = 1'b1;
        end else begin
          bus.pc_write = 1'b0;
        end
      end
      S_EXECUTE: begin
        bus.stat_en = (w_op == OP_ALU);
        bus.rs_en   = (w_op == OP_SWP);
        bus.mm_sel  = w_mem_op && (w_mm != 4'd0);
      end
      S_MEM: begin
        bus.mm_sel = w_mem_op && (w_mm != 4'd0);
        bus.dm_we  = (w_op == OP_STR);
        if (w_op == OP_SWP) begin
          bus.rf_we    = 1'b1;
          bus.data_sel = 1'b1;
          bus.rd_sel   = 1'b1;
        end else begin
          bus.rf_we = 1'b0;
        end
      end
      S_WRITEBACK: begin
        case (w_op)
          OP_ALU: bus.rf_we = 1'b1;
          OP_LOD: begin
            bus.rf_we  = 1'b1;
            bus.wb_sel = 1'b1;
            bus.rd_sel = 1'b1;
          end
          OP_SWP: begin
            bus.rf_we     = 1'b1;
            bus.data_sel  = 1'b1;
            bus.rsort_sel = 1'b1;
          end
          default: bus.rf_we = 1'b0;
        endcase
      end
      S_HALT:  bus.halted = 1'b1;
      default: bus.pc_rst = 1'b0;
    endcase
  end
endmodule

// File: tb/tb_sisc_exec_ctrl.sv
// Directed bench for sisc_exec_ctrl: a phase-indexed behavioural model checked every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_sisc_exec_ctrl;
  logic clk = 1'b0;
  logic rst_f;
  sisc_exec_ctrl_if bus ();

  sisc_exec_ctrl dut (.clk(clk), .rst_f(rst_f), .bus(bus));

  always #5 clk = ~clk;

  int          n_vec;
  int          n_err;
  int          phase;
  bit          m_halt;
  bit          exp_valid;
  bit          chk_alu;
  bit          chk_stat;
  bit          chk_br;
  logic [13:0] exp_ctrl;
  logic [31:0] exp_alu;
  logic [3:0]  exp_stat;
  logic [15:0] exp_br;
  logic [13:0] dut_ctrl;

  localparam logic [13:0] V_RESET = 14'b10_0000_0000_0000;
  localparam logic [13:0] V_HALT  = 14'b00_0000_0000_0001;

  assign dut_ctrl = {bus.pc_rst, bus.pc_write, bus.pc_sel, bus.br_sel, bus.rf_we, bus.wb_sel,
                     bus.rd_sel, bus.mm_sel, bus.dm_we, bus.rs_en, bus.rsort_sel, bus.data_sel,
                     bus.stat_en, bus.halted};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic lit1(input string name, input logic act, input logic expv);
    chk(name, {31'd0, act}, {31'd0, expv});
  endtask

  // Reference ALU from arithmetic definitions: wide sums for carry, signed range for overflow.
  function automatic logic [35:0] model_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] fn);
    longint      sa, sb, sr;
    logic [63:0] u;
    logic [31:0] r;
    logic        c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 1'b0;
    v = 1'b0;
    sr = 64'sd0;
    case (fn)
      3'd0: begin
        u  = {32'd0, a} + {32'd0, b};
        r  = u[31:0];
        c  = u[32];
        sr = sa + sb;
        v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      3'd1: begin
        r  = a - b;
        c  = (a >= b);
        sr = sa - sb;
        v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = a ^ b;
      3'd5:    r = ~a;
      3'd6:    r = a << b[4:0];
      default: r = a >> b[4:0];
    endcase
    return {c, v, r[31], (r == 32'd0), r};
  endfunction

  // Expected controls for phase 0..4 (fetch, decode, execute, mem, writeback) of one instruction.
  function automatic logic [13:0] model_ctrl(input int ph, input logic [31:0] ir,
                                             input logic [3:0] sc);
    logic [3:0] op, mm;
    logic pcw, pcs, brs, rfw, wbs, rds, mms, dmw, rse, rss, dse, sen, hit, memop;
    op = ir[31:28];
    mm = ir[27:24];
    {pcw, pcs, brs, rfw, wbs, rds, mms, dmw, rse, rss, dse, sen} = 12'd0;
    hit   = ((sc & mm) != 4'd0);
    memop = (op == 4'd2) || (op == 4'd3);
    case (ph)
      0: pcw = 1'b1;
      1: begin
        brs = (op == 4'd4) || (op == 4'd6);
        if ((((op == 4'd4) || (op == 4'd5)) && hit) || (((op == 4'd6) || (op == 4'd7)) && !hit)) begin
          pcw = 1'b1;
          pcs = 1'b1;
        end
      end
      2: begin
        sen = (op == 4'd1);
        rse = (op == 4'd8);
        mms = memop && (mm != 4'd0);
      end
      3: begin
        mms = memop && (mm != 4'd0);
        dmw = (op == 4'd3);
        if (op == 4'd8) {rfw, dse, rds} = 3'b111;
      end
      default: begin
        if (op == 4'd1) rfw = 1'b1;
        if (op == 4'd2) {rfw, wbs, rds} = 3'b111;
        if (op == 4'd8) {rfw, dse, rss} = 3'b111;
      end
    endcase
    return {1'b0, pcw, pcs, brs, rfw, wbs, rds, mms, dmw, rse, rss, dse, sen, 1'b0};
  endfunction

  task automatic set_exp();
    logic [3:0]  op, mm;
    logic [31:0] sx, b;
    op = bus.ir[31:28];
    mm = bus.ir[27:24];
    sx = {{16{bus.ir[15]}}, bus.ir[15:0]};
    exp_valid = 1'b1;
    chk_alu = 1'b0;
    chk_stat = 1'b0;
    chk_br = 1'b0;
    if (m_halt) begin
      exp_ctrl = V_HALT;
    end else begin
      exp_ctrl = model_ctrl(phase, bus.ir, bus.statcode);
      if (op == 4'd1) begin
        b = mm[3] ? sx : bus.rsb;
        {exp_stat, exp_alu} = model_alu(bus.rsa, b, mm[2:0]);
        chk_alu = 1'b1;
        chk_stat = 1'b1;
      end
      if (((op == 4'd2) || (op == 4'd3)) && (mm == 4'd0)) begin
        exp_alu = bus.rsa + sx;
        chk_alu = 1'b1;
      end
      if ((op >= 4'd4) && (op <= 4'd7)) begin
        exp_br = ((op == 4'd4) || (op == 4'd6)) ? bus.ir[15:0] : bus.pc_inc + bus.ir[15:0];
        chk_br = 1'b1;
      end
    end
  endtask

  // Per-cycle comparison against the model on the inactive edge
  always @(negedge clk) begin
    if (exp_valid) begin
      chk("ctrl", {18'd0, dut_ctrl}, {18'd0, exp_ctrl});
      if (chk_alu)  chk("alu_result", bus.alu_result, exp_alu);
      if (chk_stat) chk("stat", {28'd0, bus.stat}, {28'd0, exp_stat});
      if (chk_br)   chk("br_addr", {16'd0, bus.br_addr}, {16'd0, exp_br});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (!m_halt) begin
      if ((phase == 1) && (bus.ir[31:28] == 4'hF)) m_halt = 1'b1;
      phase = (phase + 1) % 5;
    end
    set_exp();
    #1;
  endtask

  task automatic load(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b,
                      input logic [15:0] pc, input logic [3:0] sc);
    bus.ir = ir;
    bus.rsa = a;
    bus.rsb = b;
    bus.pc_inc = pc;
    bus.statcode = sc;
    set_exp();
    #1;
  endtask

  task automatic run(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b,
                     input logic [15:0] pc, input logic [3:0] sc);
    load(ir, a, b, pc, sc);
    repeat (5) step();
  endtask

  task automatic do_reset();
    rst_f = 1'b1;
    m_halt = 1'b0;
    exp_ctrl = V_RESET;
    chk_alu = 1'b0;
    chk_stat = 1'b0;
    chk_br = 1'b0;
    exp_valid = 1'b1;
    #1;
    lit1("rst_pc_rst", bus.pc_rst, 1'b1);
    lit1("rst_rf_we", bus.rf_we, 1'b0);
    lit1("rst_halted", bus.halted, 1'b0);
    chk("rst_alu", bus.alu_result, 32'd0);
    @(posedge clk);
    #1;
    rst_f = 1'b0;
    @(posedge clk);
    #1;
    exp_ctrl = 14'd0;
    @(posedge clk);
    #1;
    phase = 0;
    set_exp();
    #1;
    lit1("rst_fetch_pcw", bus.pc_write, 1'b1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    phase = 0;
    m_halt = 1'b0;
    exp_valid = 1'b0;
    chk_alu = 1'b0;
    chk_stat = 1'b0;
    chk_br = 1'b0;
    exp_ctrl = 14'd0;
    exp_alu = 32'd0;
    exp_stat = 4'd0;
    exp_br = 16'd0;
    rst_f = 1'b1;
    bus.ir = 32'd0;
    bus.rsa = 32'd0;
    bus.rsb = 32'd0;
    bus.pc_inc = 16'd0;
    bus.statcode = 4'd0;
    @(posedge clk);
    #1;
    do_reset();

    // ADD overflow
    load(32'h1012_3000, 32'h7FFF_FFFF, 32'h0000_0001, 16'h0000, 4'h0);
    chk("add_res", bus.alu_result, 32'h8000_0000);
    chk("add_stat", {28'd0, bus.stat}, 32'h0000_0006);
    step();
    step();
    lit1("add_sten_ex", bus.stat_en, 1'b1);
    step();
    lit1("add_sten_mem", bus.stat_en, 1'b0);
    step();
    lit1("add_wb_rfwe", bus.rf_we, 1'b1);
    step();

    // SUB equal, immediate ADD
    load(32'h1112_3000, 32'h0000_0005, 32'h0000_0005, 16'h0000, 4'h0);
    chk("sub_res", bus.alu_result, 32'h0000_0000);
    chk("sub_stat", {28'd0, bus.stat}, 32'h0000_0009);
    repeat (5) step();
    load(32'h1812_FFFF, 32'h0000_0003, 32'h1234_5678, 16'h0000, 4'h0);
    chk("addi_res", bus.alu_result, 32'h0000_0002);
    repeat (5) step();

    // Remaining ALU functions against the model
    run(32'h1112_3000, 32'h0000_0003, 32'h0000_0005, 16'h0000, 4'h0);
    run(32'h1012_3000, 32'h8000_0000, 32'h8000_0000, 16'h0000, 4'h0);
    run(32'h1212_3000, 32'hF0F0_F0F0, 32'hFF00_FF00, 16'h0000, 4'h0);
    run(32'h1312_3000, 32'h0F00_0000, 32'h0000_00F0, 16'h0000, 4'h0);
    run(32'h1412_3000, 32'hAAAA_5555, 32'hFFFF_FFFF, 16'h0000, 4'h0);
    run(32'h1512_3000, 32'h0000_0000, 32'h0000_0000, 16'h0000, 4'h0);
    run(32'h1612_3000, 32'h0000_0001, 32'hFFFF_FFFF, 16'h0000, 4'h0);
    run(32'h1712_3000, 32'h8000_0000, 32'h0000_0004, 16'h0000, 4'h0);
    run(32'h1912_8001, 32'h8000_0000, 32'h0000_0000, 16'h0000, 4'h0);

    // BRR taken / not taken
    load(32'h5100_FFFE, 32'h0, 32'h0, 16'h0010, 4'h1);
    step();
    lit1("brr_pcsel", bus.pc_sel, 1'b1);
    lit1("brr_pcw", bus.pc_write, 1'b1);
    chk("brr_addr", {16'd0, bus.br_addr}, 32'h0000_000E);
    repeat (4) step();
    load(32'h5100_FFFE, 32'h0, 32'h0, 16'h0010, 4'h0);
    step();
    lit1("brr_nt_pcw", bus.pc_write, 1'b0);
    repeat (4) step();
    run(32'h4400_1234, 32'h0, 32'h0, 16'h0020, 4'h4);
    run(32'h4300_1234, 32'h0, 32'h0, 16'h0020, 4'h4);
    run(32'h6200_ABCD, 32'h0, 32'h0, 16'h0020, 4'h1);
    run(32'h7800_0005, 32'h0, 32'h0, 16'hFFFE, 4'h8);
    run(32'h7800_0005, 32'h0, 32'h0, 16'hFFFE, 4'h7);

    // LOD / STR
    load(32'h2012_0004, 32'h0000_0100, 32'h0, 16'h0000, 4'h0);
    chk("lod_addr", bus.alu_result, 32'h0000_0104);
    repeat (4) step();
    lit1("lod_rfwe", bus.rf_we, 1'b1);
    lit1("lod_wbsel", bus.wb_sel, 1'b1);
    lit1("lod_rdsel", bus.rd_sel, 1'b1);
    step();
    load(32'h3012_0008, 32'h0000_0200, 32'h0, 16'h0000, 4'h0);
    step();
    step();
    lit1("str_dmwe_ex", bus.dm_we, 1'b0);
    step();
    lit1("str_dmwe_mem", bus.dm_we, 1'b1);
    lit1("str_rfwe_mem", bus.rf_we, 1'b0);
    step();
    lit1("str_dmwe_wb", bus.dm_we, 1'b0);
    step();
    run(32'h3512_0040, 32'h0000_0200, 32'h0, 16'h0000, 4'h0);
    run(32'h2312_0044, 32'h0000_0200, 32'h0, 16'h0000, 4'h0);

    // NOP and undefined opcodes
    run(32'h0000_0000, 32'h1, 32'h2, 16'h0003, 4'hF);
    run(32'h9F12_3456, 32'h1, 32'h2, 16'h0003, 4'hF);
    run(32'hE012_3456, 32'h1, 32'h2, 16'h0003, 4'hF);

    // SWP
    load(32'h8012_3000, 32'h1111_1111, 32'h2222_2222, 16'h0000, 4'h0);
    step();
    step();
    lit1("swp_rsen", bus.rs_en, 1'b1);
    step();
    lit1("swp_mem_rfwe", bus.rf_we, 1'b1);
    lit1("swp_mem_rsort", bus.rsort_sel, 1'b0);
    step();
    lit1("swp_wb_rfwe", bus.rf_we, 1'b1);
    lit1("swp_wb_rsort", bus.rsort_sel, 1'b1);
    step();

    // Reset in the middle of EXECUTE
    load(32'h1012_3000, 32'h0000_0001, 32'h0000_0002, 16'h0000, 4'h0);
    step();
    step();
    do_reset();
    run(32'h1012_3000, 32'h0000_0010, 32'h0000_0020, 16'h0000, 4'h0);

    // HLT holds until reset
    load(32'hF000_0000, 32'h0, 32'h0, 16'h0000, 4'h0);
    step();
    step();
    lit1("hlt_halted", bus.halted, 1'b1);
    repeat (4) step();
    lit1("hlt_hold", bus.halted, 1'b1);
    lit1("hlt_no_pcw", bus.pc_write, 1'b0);
    do_reset();
    run(32'h1012_3000, 32'h0000_0007, 32'h0000_0008, 16'h0000, 4'h0);

    exp_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
